// File: rtl/oven_cycle_if.sv
// ============================================================================
// Module : oven_cycle_if
// Brief  : Setpoint/sensor inputs and heater/display outputs of the bake-cycle controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface oven_cycle_if;
  logic        pwr;
  logic        start;
  logic        cancel;
  logic        door_open;
  logic [9:0]  target_temp;
  logic [12:0] target_time;
  logic [9:0]  current_temp;
  logic        heater_on;
  logic [12:0] remaining_time;
  logic [2:0]  state;
  logic        busy;
  logic        done_alarm;
  logic        sec_tick;

  modport master (
    output pwr, start, cancel, door_open, target_temp, target_time, current_temp,
    input  heater_on, remaining_time, state, busy, done_alarm, sec_tick
  );

  modport slave (
    input  pwr, start, cancel, door_open, target_temp, target_time, current_temp,
    output heater_on, remaining_time, state, busy, done_alarm, sec_tick
  );
endinterface

`default_nettype wire

// File: rtl/oven_cycle_ctrl.sv
// ============================================================================
// Module : oven_cycle_ctrl
// Brief  : Bake-cycle sequencer: preheat, timed cook, done alarm, door pause, heater hysteresis.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module oven_cycle_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int HYST      = 5,
  parameter int MIN_TEMP  = 65,
  parameter int MAX_TEMP  = 500,
  parameter int MAX_TIME  = 1800,
  parameter int DONE_HOLD = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  oven_cycle_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DONE_HOLD + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREHEAT = 3'd1;
  localparam logic [2:0] S_COOK    = 3'd2;
  localparam logic [2:0] S_PAUSE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [PW-1:0]      C_PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]      C_DONE_LAST  = DW'(DONE_HOLD - 1);
  localparam logic [9:0]         C_MIN_TEMP   = 10'(MIN_TEMP);
  localparam logic [9:0]         C_MAX_TEMP   = 10'(MAX_TEMP);
  localparam logic [12:0]        C_MAX_TIME   = 13'(MAX_TIME);
  localparam logic signed [10:0] C_HYST       = 11'(HYST);

  logic [2:0]    r_state, n_state;
  logic [2:0]    r_saved, n_saved;
  logic [9:0]    r_tgt, n_tgt;
  logic [12:0]   r_rem, n_rem;
  logic          r_heat, n_heat;
  logic [PW-1:0] r_presc, n_presc;
  logic [DW-1:0] r_done, n_done;
  logic          r_tick, n_tick;
  logic          r_busy, r_alarm;

  logic signed [10:0] w_cur_s, w_tgt_s;
  logic               w_ge, w_below, w_heat_run;
  logic               w_wrap;
  logic [PW-1:0]      w_presc_adv;
  logic [9:0]         w_tgt_clamped;
  logic [12:0]        w_time_clamped;

  // Sign-extended compare keeps tgt-HYST from wrapping for small targets.
  assign w_cur_s    = signed'({1'b0, bus.current_temp});
  assign w_tgt_s    = signed'({1'b0, r_tgt});
  assign w_ge       = (w_cur_s >= w_tgt_s);
  assign w_below    = (w_cur_s < (w_tgt_s - C_HYST));
  assign w_heat_run = w_ge ? 1'b0 : (w_below ? 1'b1 : r_heat);

  assign w_wrap      = (r_presc == C_PRESC_LAST);
  assign w_presc_adv = w_wrap ? '0 : r_presc + PW'(1);

  assign w_tgt_clamped  = (bus.target_temp < C_MIN_TEMP) ? C_MIN_TEMP :
                          (bus.target_temp > C_MAX_TEMP) ? C_MAX_TEMP : bus.target_temp;
  assign w_time_clamped = (bus.target_time > C_MAX_TIME) ? C_MAX_TIME : bus.target_time;

  always_comb begin
    n_state = r_state;
    n_saved = r_saved;
    n_tgt   = r_tgt;
    n_rem   = r_rem;
    n_heat  = r_heat;
    n_presc = r_presc;
    n_done  = r_done;
    n_tick  = 1'b0;

    if (!bus.pwr || bus.cancel) begin
      n_state = S_IDLE;
      n_heat  = 1'b0;
      n_rem   = '0;
      n_done  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.door_open && (bus.target_time != 13'd0)) begin
            n_state = S_PREHEAT;
            n_tgt   = w_tgt_clamped;
            n_rem   = w_time_clamped;
            n_heat  = 1'b1;
          end
        end
        S_PREHEAT: begin
          if (bus.door_open) begin
            n_state = S_PAUSE;
            n_saved = S_PREHEAT;
            n_heat  = 1'b0;
          end else if (w_ge) begin
            n_state = S_COOK;
            n_presc = '0;
            n_heat  = 1'b0;
          end else begin
            n_heat  = 1'b1;
          end
        end
        S_COOK: begin
          if (bus.door_open) begin
            n_state = S_PAUSE;
            n_saved = S_COOK;
            n_heat  = 1'b0;
          end else begin
            n_presc = w_presc_adv;
            n_tick  = w_wrap;
            n_heat  = w_heat_run;
            if (w_wrap) begin
              if (r_rem <= 13'd1) begin
                n_state = S_DONE;
                n_rem   = '0;
                n_heat  = 1'b0;
                n_done  = '0;
              end else begin
                n_rem   = r_rem - 13'd1;
              end
            end
          end
        end
        S_PAUSE: begin
          // Heater was forced off while paused, so a COOK resume starts hysteresis from 0.
          if (bus.start && !bus.door_open) begin
            n_state = r_saved;
            n_heat  = (r_saved == S_PREHEAT) ? 1'b1 : w_below;
          end
        end
        S_DONE: begin
          if (bus.start) begin
            n_state = S_IDLE;
            n_done  = '0;
          end else begin
            n_presc = w_presc_adv;
            n_tick  = w_wrap;
            if (w_wrap) begin
              if (r_done == C_DONE_LAST) begin
                n_state = S_IDLE;
                n_done  = '0;
              end else begin
                n_done  = r_done + DW'(1);
              end
            end
          end
        end
        default: begin
          n_state = S_IDLE;
          n_heat  = 1'b0;
          n_rem   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_tgt   <= '0;
      r_rem   <= '0;
      r_heat  <= 1'b0;
      r_presc <= '0;
      r_done  <= '0;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= n_state;
      r_saved <= n_saved;
      r_tgt   <= n_tgt;
      r_rem   <= n_rem;
      r_heat  <= n_heat;
      r_presc <= n_presc;
      r_done  <= n_done;
      r_tick  <= n_tick;
      r_busy  <= (n_state == S_PREHEAT) || (n_state == S_COOK) || (n_state == S_PAUSE);
      r_alarm <= (n_state == S_DONE);
    end
  end

  assign bus.heater_on      = r_heat;
  assign bus.remaining_time = r_rem;
  assign bus.state          = r_state;
  assign bus.busy           = r_busy;
  assign bus.done_alarm     = r_alarm;
  assign bus.sec_tick       = r_tick;

endmodule

`default_nettype wire
